// File: rtl/ppc_diff.sv
// Two-stage stream stage that inverts a lane-wise prefix sum by adjacent differencing.
// Sideband words ride alongside each vector; a single advance signal stalls both stages together.
module ppc_diff #(
  parameter int unsigned N  = 32,
  parameter int unsigned W  = 8,
  parameter int unsigned TW = 32
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                in_valid_i,
  output logic                in_ready_o,
  input  logic [N-1:0][W-1:0] y_i,
  input  logic [TW-1:0]       a_i,
  input  logic [TW-1:0]       b_i,
  output logic                out_valid_o,
  input  logic                out_ready_i,
  output logic [N-1:0][W-1:0] x_o,
  output logic [TW-1:0]       c_o,
  output logic [TW-1:0]       d_o,
  output logic [15:0]         vec_cnt_o
);

  logic                s1_valid_q, s1_valid_d;
  logic [N-1:0][W-1:0] s1_y_q, s1_y_d;
  logic [TW-1:0]       s1_a_q, s1_a_d;
  logic [TW-1:0]       s1_b_q, s1_b_d;

  logic                s2_valid_q, s2_valid_d;
  logic [N-1:0][W-1:0] s2_x_q, s2_x_d;
  logic [TW-1:0]       s2_c_q, s2_c_d;
  logic [TW-1:0]       s2_sd_q, s2_sd_d;

  logic [15:0]         vec_cnt_q, vec_cnt_d;

  logic                advance;
  logic [N-1:0][W-1:0] diff;

  assign advance = !s2_valid_q || out_ready_i;

  // Borrow is intentionally discarded: the prefix sum itself wraps modulo 2^W.
  always_comb begin
    diff    = '0;
    diff[0] = s1_y_q[0];
    for (int unsigned i = 1; i < N; i++) begin
      diff[i] = s1_y_q[i] - s1_y_q[i-1];
    end
  end

  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_y_d     = s1_y_q;
    s1_a_d     = s1_a_q;
    s1_b_d     = s1_b_q;
    s2_valid_d = s2_valid_q;
    s2_x_d     = s2_x_q;
    s2_c_d     = s2_c_q;
    s2_sd_d    = s2_sd_q;
    vec_cnt_d  = vec_cnt_q;

    if (advance) begin
      s1_valid_d = in_valid_i;
      if (in_valid_i) begin
        s1_y_d = y_i;
        s1_a_d = a_i;
        s1_b_d = b_i;
      end
      s2_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        s2_x_d  = diff;
        s2_c_d  = s1_a_q;
        s2_sd_d = s1_b_q;
      end
    end

    if (s2_valid_q && out_ready_i) begin
      vec_cnt_d = vec_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      s1_valid_q <= 1'b0;
      s1_y_q     <= '0;
      s1_a_q     <= '0;
      s1_b_q     <= '0;
      s2_valid_q <= 1'b0;
      s2_x_q     <= '0;
      s2_c_q     <= '0;
      s2_sd_q    <= '0;
      vec_cnt_q  <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_y_q     <= s1_y_d;
      s1_a_q     <= s1_a_d;
      s1_b_q     <= s1_b_d;
      s2_valid_q <= s2_valid_d;
      s2_x_q     <= s2_x_d;
      s2_c_q     <= s2_c_d;
      s2_sd_q    <= s2_sd_d;
      vec_cnt_q  <= vec_cnt_d;
    end
  end

  assign in_ready_o  = advance;
  assign out_valid_o = s2_valid_q;
  assign x_o         = s2_x_q;
  assign c_o         = s2_c_q;
  assign d_o         = s2_sd_q;
  assign vec_cnt_o   = vec_cnt_q;

endmodule

// File: tb/tb_ppc_diff.sv
// Bench for ppc_diff: fixed vector table, handshake corner sequences, and a randomized
// round trip through a prefix-sum model with a queue scoreboard.
module tb_ppc_diff;
  localparam int unsigned N  = 32;
  localparam int unsigned W  = 8;
  localparam int unsigned TW = 32;

  typedef logic [N-1:0][W-1:0] lanes_t;
  typedef struct {
    lanes_t        y;
    logic [TW-1:0] a;
    logic [TW-1:0] b;
    lanes_t        x;
  } vec_t;
  typedef struct {
    lanes_t        e;
    logic [TW-1:0] a;
    logic [TW-1:0] b;
  } item_t;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic          out_valid;
  logic          out_ready = 1'b0;
  lanes_t        y = '0;
  lanes_t        x;
  logic [TW-1:0] a = '0, b = '0, c, d;
  logic [15:0]   vec_cnt;

  int n_vec = 0;
  int n_bad = 0;

  vec_t          tbl [5];
  item_t         q [$];
  item_t         it;
  lanes_t        es [4];
  logic [TW-1:0] as [4], bs [4];
  lanes_t        prev_x;
  logic          prev_stall;
  int            oi, sent, got, hold, accepted, delivered, model_cnt;
  logic          holding;

  always #5 clk = ~clk;

  ppc_diff #(.N(N), .W(W), .TW(TW)) dut (
    .clk_i      (clk),
    .rst_ni     (rst_n),
    .in_valid_i (in_valid),
    .in_ready_o (in_ready),
    .y_i        (y),
    .a_i        (a),
    .b_i        (b),
    .out_valid_o(out_valid),
    .out_ready_i(out_ready),
    .x_o        (x),
    .c_o        (c),
    .d_o        (d),
    .vec_cnt_o  (vec_cnt)
  );

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, want %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  function automatic lanes_t rand_lanes();
    lanes_t v;
    for (int i = 0; i < N; i++) v[i] = W'($urandom);
    return v;
  endfunction

  // Stand-in for the upstream prefix pipeline: running sum modulo 2^W.
  function automatic lanes_t prefix(input lanes_t e);
    lanes_t       p;
    logic [W-1:0] s;
    s = '0;
    for (int i = 0; i < N; i++) begin
      s    = s + e[i];
      p[i] = s;
    end
    return p;
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout, want completion");
    $fatal(1, "timeout");
  end

  initial begin
    for (int i = 0; i < N; i++) begin
      tbl[0].y[i] = W'(i + 1);
      tbl[0].x[i] = 8'h01;
      tbl[1].y[i] = (i == 0) ? 8'hFF : 8'h01;
      tbl[1].x[i] = (i == 0) ? 8'hFF : ((i == 1) ? 8'h02 : 8'h00);
      tbl[2].y[i] = 8'h55;
      tbl[2].x[i] = (i == 0) ? 8'h55 : 8'h00;
      tbl[3].y[i] = W'(3 * i);
      tbl[3].x[i] = (i == 0) ? 8'h00 : 8'h03;
      tbl[4].y[i] = W'(255 - i);
      tbl[4].x[i] = 8'hFF;
    end
    tbl[0].a = 32'hDEADBEEF;
    tbl[0].b = 32'h12345678;
    for (int k = 1; k < 5; k++) begin
      tbl[k].a = $urandom;
      tbl[k].b = $urandom;
    end

    // Reset state
    do_reset();
    out_ready = 1'b0;
    #1;
    chk("rst_out_valid", 256'(out_valid), 256'(0));
    chk("rst_x", 256'(x), 256'(0));
    chk("rst_c", 256'(c), 256'(0));
    chk("rst_d", 256'(d), 256'(0));
    chk("rst_vec_cnt", 256'(vec_cnt), 256'(0));
    chk("rst_in_ready", 256'(in_ready), 256'(1));

    // Table vectors streamed back to back
    do_reset();
    oi = 0;
    for (int j = 0; j < 8; j++) begin
      in_valid  = (j < 5);
      out_ready = 1'b1;
      if (j < 5) begin
        y = tbl[j].y;
        a = tbl[j].a;
        b = tbl[j].b;
      end
      @(negedge clk);
      chk("tbl_out_valid", 256'(out_valid), 256'(j >= 2 && j < 7));
      if (out_valid && oi < 5) begin
        chk("tbl_x", 256'(x), 256'(tbl[oi].x));
        chk("tbl_c", 256'(c), 256'(tbl[oi].a));
        chk("tbl_d", 256'(d), 256'(tbl[oi].b));
        oi++;
      end
      tick();
    end
    in_valid = 1'b0;
    chk("tbl_vec_cnt", 256'(vec_cnt), 256'(5));

    // Backpressure: 4 vectors, 3 stalled cycles after first out_valid
    do_reset();
    for (int k = 0; k < 4; k++) begin
      es[k] = rand_lanes();
      as[k] = $urandom;
      bs[k] = $urandom;
    end
    sent = 0;
    got  = 0;
    hold = 0;
    for (int cyc = 0; cyc < 40 && got < 4; cyc++) begin
      in_valid = (sent < 4);
      y        = prefix(es[sent % 4]);
      a        = as[sent % 4];
      b        = bs[sent % 4];
      holding  = out_valid && (hold < 3);
      out_ready = !holding;
      if (holding) hold++;
      @(negedge clk);
      if (holding) begin
        chk("bp_in_ready_low", 256'(in_ready), 256'(0));
        chk("bp_x_held", 256'(x), 256'(es[0]));
      end
      if (in_valid && in_ready) sent++;
      if (out_valid && out_ready) begin
        chk("bp_x", 256'(x), 256'(es[got]));
        chk("bp_c", 256'(c), 256'(as[got]));
        chk("bp_d", 256'(d), 256'(bs[got]));
        got++;
      end
      tick();
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    chk("bp_delivered", 256'(got), 256'(4));
    chk("bp_hold_cycles", 256'(hold), 256'(3));
    tick();
    chk("bp_no_dup", 256'(out_valid), 256'(0));
    chk("bp_vec_cnt", 256'(vec_cnt), 256'(4));

    // Bubbles: in_valid 1,0,1,0
    do_reset();
    for (int j = 0; j < 8; j++) begin
      in_valid  = (j < 4) && (j % 2 == 0);
      y         = rand_lanes();
      out_ready = 1'b1;
      @(negedge clk);
      chk("bub_out_valid", 256'(out_valid), 256'(j == 2 || j == 4));
      tick();
    end
    in_valid = 1'b0;
    chk("bub_vec_cnt", 256'(vec_cnt), 256'(2));

    // Reset while both stages hold valid data
    do_reset();
    for (int j = 0; j < 5; j++) begin
      in_valid  = 1'b1;
      out_ready = 1'b1;
      y         = rand_lanes();
      a         = $urandom | 32'h1;
      b         = $urandom | 32'h1;
      @(negedge clk);
      if (j == 4) begin
        chk("mid_pre_out_valid", 256'(out_valid), 256'(1));
        chk("mid_pre_vec_cnt", 256'(vec_cnt), 256'(2));
        rst_n = 1'b0;
      end
      tick();
    end
    rst_n     = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    #1;
    chk("mid_out_valid", 256'(out_valid), 256'(0));
    chk("mid_x", 256'(x), 256'(0));
    chk("mid_c", 256'(c), 256'(0));
    chk("mid_d", 256'(d), 256'(0));
    chk("mid_vec_cnt", 256'(vec_cnt), 256'(0));
    chk("mid_in_ready", 256'(in_ready), 256'(1));

    // Randomized round trip against the prefix model
    do_reset();
    accepted   = 0;
    delivered  = 0;
    model_cnt  = 0;
    prev_stall = 1'b0;
    prev_x     = '0;
    q.delete();
    for (int cyc = 0; cyc < 6000 && delivered < 1000; cyc++) begin
      in_valid  = (accepted < 1000) && ($urandom_range(0, 3) != 0);
      it.e      = rand_lanes();
      it.a      = $urandom;
      it.b      = $urandom;
      y         = prefix(it.e);
      a         = it.a;
      b         = it.b;
      out_ready = ($urandom_range(0, 3) != 0);
      @(negedge clk);
      chk("rt_in_ready", 256'(in_ready), 256'(!out_valid || out_ready));
      chk("rt_vec_cnt", 256'(vec_cnt), 256'(16'(model_cnt)));
      if (prev_stall) chk("rt_stall_stable", 256'(x), 256'(prev_x));
      if (in_valid && in_ready) begin
        q.push_back(it);
        accepted++;
      end
      if (out_valid && out_ready) begin
        if (q.size() == 0) begin
          chk("rt_unexpected_out", 256'(1), 256'(0));
        end else begin
          it = q.pop_front();
          chk("rt_x", 256'(x), 256'(it.e));
          chk("rt_c", 256'(c), 256'(it.a));
          chk("rt_d", 256'(d), 256'(it.b));
        end
        delivered++;
        model_cnt++;
      end
      prev_stall = out_valid && !out_ready;
      prev_x     = x;
      tick();
    end
    in_valid = 1'b0;
    chk("rt_delivered", 256'(delivered), 256'(1000));
    chk("rt_queue_empty", 256'(q.size()), 256'(0));
    chk("rt_final_cnt", 256'(vec_cnt), 256'(16'(model_cnt)));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
